// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: FSM encodings, default sizes
// and the per-cycle control bundle.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DIV_WAIT  = 2'd1,
    ST_DIV_ABORT = 2'd2
  } state_t;

  localparam int DIV_TIMEOUT_DEF = 40;
  localparam int CNT_W_DEF       = 32;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_exe;
    logic stall_mem;
    logic flush_id;
    logic flush_exe;
    logic flush_mem;
    logic div_timeout_err;
  } ctrl_t;

  // Front end frozen while a bubble drains into EXE/MEM (load-use, divide).
  function automatic ctrl_t ctrl_hold_exe();
    ctrl_t c;
    c           = '0;
    c.stall_if  = 1'b1;
    c.stall_id  = 1'b1;
    c.stall_exe = 1'b1;
    c.flush_mem = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard flags in, per-stage stall/flush controls out; slave side is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = hazard_ctrl_pkg::CNT_W_DEF
);
  import hazard_ctrl_pkg::*;

  // No valid/ready pair: every input is a level flag sampled each cycle, and
  // exe_div_start (request, level) / div_done (one-cycle ack) form the only
  // handshake; outputs answer in the same cycle.
  logic             hzd_exe_to_id_A;
  logic             hzd_mem_to_exe_A;
  logic             hzd_mem_to_exe_B;
  logic             id_jump;
  logic             exe_branch_taken;
  logic             exe_div_start;
  logic             div_done;
  logic             stall_if;
  logic             stall_id;
  logic             stall_exe;
  logic             stall_mem;
  logic             flush_id;
  logic             flush_exe;
  logic             flush_mem;
  logic             div_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  state_t           dbg_state;

  modport master (
    output hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B, id_jump,
           exe_branch_taken, exe_div_start, div_done,
    input  stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe,
           flush_mem, div_timeout_err, stall_cnt, flush_cnt, dbg_state
  );

  modport slave (
    input  hzd_exe_to_id_A, hzd_mem_to_exe_A, hzd_mem_to_exe_B, id_jump,
           exe_branch_taken, exe_div_start, div_done,
    output stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe,
           flush_mem, div_timeout_err, stall_cnt, flush_cnt, dbg_state
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush decode plus divider-wait FSM
// with watchdog. Optional performance counters under HZD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         nrst,
  hazard_ctrl_if.slave bus
);

  localparam int WD_W = $clog2(DIV_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] stall_cnt_w;
  logic [CNT_W-1:0] flush_cnt_w;

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    ctrl    = '0;
    case (state_q)
      ST_RUN: begin
        if (bus.exe_div_start) begin
          ctrl    = ctrl_hold_exe();
          state_d = ST_DIV_WAIT;
          wd_d    = '0;
        end else if (bus.hzd_mem_to_exe_A || bus.hzd_mem_to_exe_B) begin
          // Branch waits: it re-resolves next cycle with forwarded data.
          ctrl = ctrl_hold_exe();
        end else if (bus.exe_branch_taken) begin
          ctrl.flush_id  = 1'b1;
          ctrl.flush_exe = 1'b1;
        end else if (bus.hzd_exe_to_id_A) begin
          ctrl.stall_if  = 1'b1;
          ctrl.stall_id  = 1'b1;
          ctrl.flush_exe = 1'b1;
        end else if (bus.id_jump) begin
          ctrl.flush_id = 1'b1;
        end
      end
      ST_DIV_WAIT: begin
        if (bus.div_done) begin
          state_d = ST_RUN;
        end else begin
          ctrl = ctrl_hold_exe();
          wd_d = wd_q + WD_W'(1);
          if (wd_q == WD_LAST) begin
            state_d = ST_DIV_ABORT;
          end
        end
      end
      ST_DIV_ABORT: begin
        ctrl.flush_exe       = 1'b1;
        ctrl.flush_mem       = 1'b1;
        ctrl.div_timeout_err = 1'b1;
        state_d              = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Reset cycle bubbles every stage regardless of the registered state.
    if (!nrst) begin
      ctrl           = '0;
      ctrl.flush_id  = 1'b1;
      ctrl.flush_exe = 1'b1;
      ctrl.flush_mem = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

`ifdef HZD_PERF_CNT_EN
  logic stall_any;
  logic flush_any;

  assign stall_any = ctrl.stall_if | ctrl.stall_id | ctrl.stall_exe | ctrl.stall_mem;
  assign flush_any = nrst & (ctrl.flush_id | ctrl.flush_exe);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (nrst),
    .inc   (stall_any),
    .cnt   (stall_cnt_w)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (nrst),
    .inc   (flush_any),
    .cnt   (flush_cnt_w)
  );
`else
  assign stall_cnt_w = '0;
  assign flush_cnt_w = '0;
`endif

  assign bus.stall_if        = ctrl.stall_if;
  assign bus.stall_id        = ctrl.stall_id;
  assign bus.stall_exe       = ctrl.stall_exe;
  assign bus.stall_mem       = ctrl.stall_mem;
  assign bus.flush_id        = ctrl.flush_id;
  assign bus.flush_exe       = ctrl.flush_exe;
  assign bus.flush_mem       = ctrl.flush_mem;
  assign bus.div_timeout_err = ctrl.div_timeout_err;
  assign bus.stall_cnt       = stall_cnt_w;
  assign bus.flush_cnt       = flush_cnt_w;
  assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int CNT_W = 32;
  localparam int EXP_W = 1 + 2 + 4 + 3 + 1 + CNT_W + CNT_W;
`ifdef HZD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Input bits: {exe_to_id_A, mem_to_exe_A, mem_to_exe_B, id_jump, branch, div_start, div_done}
  localparam logic [6:0] I_EID  = 7'b1000000;
  localparam logic [6:0] I_MA   = 7'b0100000;
  localparam logic [6:0] I_MB   = 7'b0010000;
  localparam logic [6:0] I_JMP  = 7'b0001000;
  localparam logic [6:0] I_BR   = 7'b0000100;
  localparam logic [6:0] I_DIV  = 7'b0000010;
  localparam logic [6:0] I_DONE = 7'b0000001;
  localparam logic [6:0] I_NONE = 7'b0000000;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_HOLD = 4'b1110;
  localparam logic [3:0] S_FE   = 4'b1100;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;
  int   vec_n;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.DIV_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (hif)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one call per clock cycle; counter expectations come from a
  // running tally of the expected stall/flush flags.
  task automatic cyc(input logic rst_n, input logic [6:0] in, input logic [1:0] st,
                     input logic [3:0] stl, input logic [2:0] fl, input logic err,
                     input logic chk);
    @(posedge clk);
    #1;
    nrst = rst_n;
    {hif.hzd_exe_to_id_A, hif.hzd_mem_to_exe_A, hif.hzd_mem_to_exe_B, hif.id_jump,
     hif.exe_branch_taken, hif.exe_div_start, hif.div_done} = in;
    exp_q.push_back({chk, st, stl, fl, err,
                     (PERF_EN ? m_stall : {CNT_W{1'b0}}),
                     (PERF_EN ? m_flush : {CNT_W{1'b0}})});
    if (!rst_n) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (stl != 4'b0000) m_stall = m_stall + 1;
      if (fl[2] || fl[1]) m_flush = m_flush + 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%h exp=%h", name, vec_n, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("stall", 32'({hif.stall_if, hif.stall_id, hif.stall_exe, hif.stall_mem}),
            32'(e[71:68]));
      check("flush", 32'({hif.flush_id, hif.flush_exe, hif.flush_mem}), 32'(e[67:65]));
      check("timeout_err", 32'(hif.div_timeout_err), 32'(e[64]));
      check("stall_flush_overlap",
            32'((hif.stall_id & hif.flush_id) | (hif.stall_exe & hif.flush_exe) |
                (hif.stall_mem & hif.flush_mem)), 32'd0);
      if (e[74]) begin
        check("state", 32'(hif.dbg_state), 32'(e[73:72]));
        check("stall_cnt", hif.stall_cnt, e[63:32]);
        check("flush_cnt", hif.flush_cnt, e[31:0]);
      end
      vec_n++;
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    vec_n   = 0;
    m_stall = '0;
    m_flush = '0;
    nrst    = 1'b0;
    {hif.hzd_exe_to_id_A, hif.hzd_mem_to_exe_A, hif.hzd_mem_to_exe_B, hif.id_jump,
     hif.exe_branch_taken, hif.exe_div_start, hif.div_done} = I_NONE;

    // Power-up reset, then single-cycle hazards in RUN
    cyc(0, I_NONE, ST_RUN, S_NONE, 3'b111, 0, 0);
    cyc(0, I_NONE, ST_RUN, S_NONE, 3'b111, 0, 1);
    cyc(1, I_NONE, ST_RUN, S_NONE, 3'b000, 0, 1);
    cyc(1, I_MB, ST_RUN, S_HOLD, 3'b001, 0, 1);
    cyc(1, I_NONE, ST_RUN, S_NONE, 3'b000, 0, 1);
    cyc(1, I_MA | I_BR, ST_RUN, S_HOLD, 3'b001, 0, 1);
    cyc(1, I_EID | I_BR, ST_RUN, S_NONE, 3'b110, 0, 1);
    cyc(1, I_EID, ST_RUN, S_FE, 3'b010, 0, 1);
    cyc(1, I_JMP, ST_RUN, S_NONE, 3'b100, 0, 1);
    cyc(1, I_BR | I_JMP, ST_RUN, S_NONE, 3'b110, 0, 1);
    cyc(1, I_MB | I_EID | I_JMP, ST_RUN, S_HOLD, 3'b001, 0, 1);
    cyc(1, I_NONE, ST_RUN, S_NONE, 3'b000, 0, 1);

    // Divide from a fresh reset: 1 issue cycle + 5 waits, done on the next
    cyc(0, I_NONE, ST_RUN, S_NONE, 3'b111, 0, 1);
    cyc(1, I_DIV | I_DONE, ST_RUN, S_HOLD, 3'b001, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, I_DIV | ((i == 2) ? (I_MA | I_BR | I_EID) : I_NONE), ST_DIV_WAIT, S_HOLD,
          3'b001, 0, 1);
    end
    cyc(1, I_DIV | I_DONE, ST_DIV_WAIT, S_NONE, 3'b000, 0, 1);
    cyc(1, I_NONE, ST_RUN, S_NONE, 3'b000, 0, 1);
    if (PERF_EN) check("div_stall_total", m_stall, 32'd6);

    // Watchdog: DIV_TIMEOUT=8 wait cycles, abort 9 cycles after issue
    cyc(1, I_DIV, ST_RUN, S_HOLD, 3'b001, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1, I_DIV, ST_DIV_WAIT, S_HOLD, 3'b001, 0, 1);
    end
    cyc(1, I_NONE, ST_DIV_ABORT, S_NONE, 3'b011, 1, 1);
    cyc(1, I_NONE, ST_RUN, S_NONE, 3'b000, 0, 1);

    // div_done on the last watchdog cycle still completes normally
    cyc(1, I_DIV, ST_RUN, S_HOLD, 3'b001, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(1, I_DIV, ST_DIV_WAIT, S_HOLD, 3'b001, 0, 1);
    end
    cyc(1, I_DIV | I_DONE, ST_DIV_WAIT, S_NONE, 3'b000, 0, 1);
    cyc(1, I_NONE, ST_RUN, S_NONE, 3'b000, 0, 1);

    // Reset mid-DIV_WAIT: back to RUN, no timeout afterwards
    cyc(1, I_DIV, ST_RUN, S_HOLD, 3'b001, 0, 1);
    cyc(1, I_DIV, ST_DIV_WAIT, S_HOLD, 3'b001, 0, 1);
    cyc(1, I_DIV, ST_DIV_WAIT, S_HOLD, 3'b001, 0, 1);
    cyc(0, I_DIV, ST_DIV_WAIT, S_NONE, 3'b111, 0, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, I_NONE, ST_RUN, S_NONE, 3'b000, 0, 1);
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
